snn_csr_router: RTL and testbench
=================================

Name: snn_csr_router

Overview:
Parametrised CSR access router for multi-unit SNN arrays. Generalises the fixed per-unit U0/U1 base-address map to NUM_UNITS units.
- Accepts single host read/write requests over a valid/ready handshake.
- Decodes the address into unit index, register region (weight / spike-thresh / neuron-thresh / control-status) and offset.
- Forwards the access to the selected unit and returns its response.
- Adds decode-error and timeout reporting.
- Sits between the host CSR bus and the per-unit register banks.

Parameters:
NUM_UNITS, 2, number of network units addressed
ADDR_WIDTH, 16, host address width
DATA_WIDTH, 32, CSR data width
UNIT_STRIDE, 16'h6000, address distance between unit bases (unit u base = u*UNIT_STRIDE)
REGION_SIZE, 16'h1000, bytes per region; must be a power of 2
NUM_REGIONS, 4, valid regions per unit (0 weight, 1 spike thresh, 2 neuron thresh, 3 control/status)
TIMEOUT_CYCLES, 64, max cycles waiting for unit_ack before error

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  host request valid
req_ready  output  1  router can accept a request
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  output  1  decode error or timeout
unit_req  output  NUM_UNITS  one-hot access strobe, held until ack
unit_region  output  $clog2(NUM_REGIONS)  decoded region index
unit_offset  output  $clog2(REGION_SIZE)  offset within region
unit_write  output  1  registered req_write
unit_wdata  output  DATA_WIDTH  registered req_wdata
unit_ack  input  NUM_UNITS  per-unit completion, one cycle
unit_rdata  input  NUM_UNITS*DATA_WIDTH  per-unit read data, unit u at [u*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset values: req_ready=0 during rst, 1 the cycle after; rsp_valid=0, rsp_err=0, rsp_rdata=0, unit_req=0, unit_region=0, unit_offset=0, unit_write=0, unit_wdata=0, timeout counter=0; FSM=IDLE.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: req_ready=1. Handshake is req_valid&&req_ready; capture write flag, wdata and decoded fields.
- Decode: unit u = largest u < NUM_UNITS with req_addr >= u*UNIT_STRIDE. rel = req_addr - u*UNIT_STRIDE; region = rel / REGION_SIZE; offset = rel % REGION_SIZE. Error if region >= NUM_REGIONS.
- Valid decode: IDLE->ISSUE, unit_req[u]=1 from the next cycle.
- Error: IDLE->RESP directly with rsp_err=1, rsp_rdata=0, no unit strobe. rsp_valid appears 1 cycle after acceptance.
- ISSUE: unit_req and all unit_* fields held stable. Counter increments each cycle.
  - unit_ack[u] of the selected unit -> RESP next cycle. rsp_rdata = unit_rdata[u] for reads, 0 for writes; rsp_err=0; unit_req cleared.
  - Acks from non-selected units are ignored.
  - Counter reaching TIMEOUT_CYCLES-1 without ack -> RESP with rsp_err=1, rsp_rdata=0, unit_req cleared. An ack in that same cycle wins; no error.
- Latency: ack in cycle k of ISSUE -> rsp_valid in cycle k+1. Minimum round trip is 3 cycles (accept, issue+ack, resp).
- RESP: rsp_valid=1 with data/err stable until rsp_ready. On rsp_ready -> IDLE, rsp_valid=0 next cycle, counter cleared.
- req_ready=0 in ISSUE and RESP. Only one outstanding transaction.
- rst mid-transaction: abort immediately, all outputs to reset values, no response generated.

Optional Feature:
SNN_CSR_ROUTER_STATS_EN:
- Defined: adds outputs stat_txn_cnt (16b) and stat_err_cnt (16b), saturating at 16'hFFFF, cleared by rst.
  - txn increments on every completed response handshake.
  - err increments when that response has rsp_err=1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Read 0x7004 (defaults), unit1 acks 2 cycles after strobe with 0xCAFE0001 -> unit_req=2'b10, region=1, offset=0x004; rsp_valid with rdata=0xCAFE0001, err=0.
- Write 0x3010 data 0x5A -> unit_req=2'b01, region=3, offset=0x010, unit_wdata=0x5A; after ack rsp_rdata=0, err=0.
- Read 0x5000 -> region 5 >= 4; no unit_req; rsp_valid 1 cycle after accept with err=1, rdata=0.
- Read 0x0008, unit0 never acks -> unit_req dropped after 64 cycles; rsp_err=1. A spurious unit_ack[1] during the wait is ignored.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid/rdata stable, req_ready=0, new req_valid not accepted.
- Assert rst while in ISSUE -> next cycle unit_req=0, rsp_valid=0, FSM IDLE. With stats enabled, counters read 0.

Source files
------------

// File: rtl/snn_csr_router.sv
// snn_csr_router: host CSR access router for NUM_UNITS SNN units. Defining SNN_CSR_ROUTER_STATS_EN adds saturating transaction/error counters.
module snn_csr_router #(
    parameter int          NUM_UNITS      = 2,
    parameter int          ADDR_WIDTH     = 16,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned UNIT_STRIDE    = 16'h6000,
    parameter int unsigned REGION_SIZE    = 16'h1000,
    parameter int          NUM_REGIONS    = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    localparam int         RW             = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1,
    localparam int         OW             = $clog2(REGION_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [NUM_UNITS-1:0]            unit_req,
    output logic [RW-1:0]                   unit_region,
    output logic [OW-1:0]                   unit_offset,
    output logic                            unit_write,
    output logic [DATA_WIDTH-1:0]           unit_wdata,
    input  logic [NUM_UNITS-1:0]            unit_ack,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_rdata
`ifdef SNN_CSR_ROUTER_STATS_EN
    ,
    output logic [15:0]                     stat_txn_cnt,
    output logic [15:0]                     stat_err_cnt
`endif
);
    localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                 state_q, state_d;
    logic [UW-1:0]          unit_sel_q, unit_sel_d;
    logic [NUM_UNITS-1:0]   unit_req_q, unit_req_d;
    logic [RW-1:0]          region_q, region_d;
    logic [OW-1:0]          offset_q, offset_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [UW-1:0]          dec_unit;
    logic [31:0]            dec_rel;
    logic [31:0]            dec_region;
    logic                   dec_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   ack_hit;

    // Highest unit whose base lies at or below the address owns it.
    always_comb begin
        dec_unit = '0;
        dec_rel  = 32'(req_addr);
        for (int u = 1; u < NUM_UNITS; u++)
            if (32'(req_addr) >= 32'(u) * UNIT_STRIDE) begin
                dec_unit = UW'(u);
                dec_rel  = 32'(req_addr) - 32'(u) * UNIT_STRIDE;
            end
    end

    assign dec_region = dec_rel >> OW;
    assign dec_err    = dec_region >= 32'(NUM_REGIONS);
    assign sel_rdata  = unit_rdata[32'(unit_sel_q) * DATA_WIDTH +: DATA_WIDTH];
    assign ack_hit    = unit_ack[unit_sel_q];

    always_comb begin
        state_d    = state_q;
        unit_sel_d = unit_sel_q;
        unit_req_d = unit_req_q;
        region_d   = region_q;
        offset_d   = offset_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (state_q == IDLE && req_valid) begin
            unit_sel_d = dec_unit;
            region_d   = dec_region[RW-1:0];
            offset_d   = dec_rel[OW-1:0];
            write_d    = req_write;
            wdata_d    = req_wdata;
            cnt_d      = '0;
            rdata_d    = '0;
            err_d      = dec_err;
            unit_req_d = dec_err ? '0 : NUM_UNITS'(1) << dec_unit;
            state_d    = dec_err ? RESP : ISSUE;
        end else if (state_q == ISSUE) begin
            cnt_d = cnt_q + CW'(1);
            // A same-cycle ack takes precedence over the timeout.
            if (ack_hit || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d    = RESP;
                unit_req_d = '0;
                err_d      = !ack_hit;
                rdata_d    = (ack_hit && !write_q) ? sel_rdata : '0;
            end
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
            rdata_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            unit_sel_q <= '0;
            unit_req_q <= '0;
            region_q   <= '0;
            offset_q   <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_sel_q <= unit_sel_d;
            unit_req_q <= unit_req_d;
            region_q   <= region_d;
            offset_q   <= offset_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_ready   = state_q == IDLE && !rst;
    assign rsp_valid   = state_q == RESP;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign unit_req    = unit_req_q;
    assign unit_region = region_q;
    assign unit_offset = offset_q;
    assign unit_write  = write_q;
    assign unit_wdata  = wdata_q;

`ifdef SNN_CSR_ROUTER_STATS_EN
    logic [15:0] txn_q, errc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q  <= '0;
            errc_q <= '0;
        end else if (state_q == RESP && rsp_ready) begin
            if (txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
            if (err_q && errc_q != 16'hFFFF) errc_q <= errc_q + 16'd1;
        end
    end

    assign stat_txn_cnt = txn_q;
    assign stat_err_cnt = errc_q;
`endif
endmodule

// File: tb/tb_snn_csr_router.sv
// tb_snn_csr_router: table-driven, hand-sequenced and randomized checks of snn_csr_router against a decode/latency model.
module tb_snn_csr_router;
    localparam int NU = 2;
    localparam int DW = 32;

    logic           clk = 0;
    logic           rst;
    logic           req_valid, req_write, rsp_ready;
    logic           req_ready, rsp_valid, rsp_err, unit_write;
    logic [15:0]    req_addr;
    logic [DW-1:0]  req_wdata, rsp_rdata, unit_wdata;
    logic [NU-1:0]  unit_req, unit_ack;
    logic [1:0]     unit_region;
    logic [11:0]    unit_offset;
    logic [NU*DW-1:0] unit_rdata;
`ifdef SNN_CSR_ROUTER_STATS_EN
    logic [15:0]    stat_txn_cnt, stat_err_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int exp_txn = 0;
    int exp_errc = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wd;
        int          dly;
        logic [31:0] rd;
        int          hold;
        bit          spur;
        logic [1:0]  e_req;
        logic [1:0]  e_reg;
        logic [11:0] e_off;
        int          e_cyc;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    always #5 clk = ~clk;

    snn_csr_router dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .unit_req(unit_req), .unit_region(unit_region), .unit_offset(unit_offset),
        .unit_write(unit_write), .unit_wdata(unit_wdata),
        .unit_ack(unit_ack), .unit_rdata(unit_rdata)
`ifdef SNN_CSR_ROUTER_STATS_EN
        , .stat_txn_cnt(stat_txn_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected behaviour computed directly from the address map and latency rules.
    function automatic vec_t model(logic wr, logic [15:0] a, logic [31:0] wd, int dly,
                                   logic [31:0] rd, int hold, bit spur);
        vec_t v;
        int u, rel, rg;
        u = 0;
        for (int k = 0; k < NU; k++) if (int'(a) >= k * 'h6000) u = k;
        rel = int'(a) - u * 'h6000;
        rg = rel / 'h1000;
        v.wr = wr; v.addr = a; v.wd = wd; v.dly = dly; v.rd = rd; v.hold = hold; v.spur = spur;
        v.e_reg = rg[1:0];
        v.e_off = 12'(rel % 'h1000);
        if (rg >= 4) begin
            v.e_req = '0; v.e_cyc = 0; v.e_err = 1; v.e_rdata = 0;
        end else if (dly >= 0 && dly < 64) begin
            v.e_req = 2'(1 << u); v.e_cyc = dly + 1; v.e_err = 0; v.e_rdata = wr ? 32'h0 : rd;
        end else begin
            v.e_req = 2'(1 << u); v.e_cyc = 64; v.e_err = 1; v.e_rdata = 0;
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int n;
        req_valid = 1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wd;
        chk("req_ready_idle", req_ready, 1);
        step();
        req_valid = 0;
        if (v.e_cyc == 0) begin
            chk("dec_err_rsp_valid", rsp_valid, 1);
            chk("dec_err_unit_req", unit_req, 0);
        end else begin
            chk("unit_req", unit_req, v.e_req);
            chk("unit_region", unit_region, v.e_reg);
            chk("unit_offset", unit_offset, v.e_off);
            chk("unit_write", unit_write, v.wr);
            chk("unit_wdata", unit_wdata, v.wd);
            unit_rdata = {$urandom, $urandom};
            for (int k = 0; k < NU; k++) if (v.e_req[k]) unit_rdata[k*DW +: DW] = v.rd;
            n = 0;
            while (!rsp_valid && n < 100) begin
                chk("unit_req_held", unit_req, v.e_req);
                unit_ack = (n == v.dly) ? v.e_req : (v.spur ? ~v.e_req : '0);
                step();
                n++;
            end
            unit_ack = 0;
            unit_rdata = {$urandom, $urandom};
            chk("issue_cycles", n, v.e_cyc);
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, v.e_err);
        chk("rsp_rdata", rsp_rdata, v.e_rdata);
        chk("unit_req_cleared", unit_req, 0);
        chk("req_ready_busy", req_ready, 0);
        for (int i = 0; i < v.hold; i++) begin
            req_valid = 1; req_write = 0; req_addr = 16'h7004;
            step();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, v.e_rdata);
            chk("hold_rsp_err", rsp_err, v.e_err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_unit_req", unit_req, 0);
        end
        req_valid = 0; rsp_ready = 1;
        step();
        rsp_ready = 0;
        exp_txn++;
        if (v.e_err) exp_errc++;
        chk("rsp_done_valid", rsp_valid, 0);
        chk("rsp_done_ready", req_ready, 1);
        chk("rsp_done_unit_req", unit_req, 0);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int r, dly;
        rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0; unit_ack = 0; unit_rdata = 0;
        step(); step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_unit_req", unit_req, 0);
        chk("rst_unit_fields", {unit_region, unit_offset, unit_write, unit_wdata}, 0);
        rst = 0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        //        wr addr      wdata         dly rd            hold spur req    reg   off      cyc err rdata
        tbl[0] = '{0, 16'h7004, 32'h0,        2,  32'hCAFE0001, 0,  0, 2'b10, 2'd1, 12'h004, 3,  0, 32'hCAFE0001};
        tbl[1] = '{1, 16'h3010, 32'h5A,       0,  32'hDEADBEEF, 0,  0, 2'b01, 2'd3, 12'h010, 1,  0, 32'h0};
        tbl[2] = '{0, 16'h5000, 32'h0,        0,  32'h0,        0,  0, 2'b00, 2'd1, 12'h000, 0,  1, 32'h0};
        tbl[3] = '{0, 16'h0008, 32'h0,        -1, 32'h11111111, 0,  1, 2'b01, 2'd0, 12'h008, 64, 1, 32'h0};
        tbl[4] = '{0, 16'h6FFC, 32'h0,        0,  32'h12345678, 10, 0, 2'b10, 2'd0, 12'hFFC, 1,  0, 32'h12345678};
        tbl[5] = '{0, 16'h9ABC, 32'h0,        63, 32'h0BADF00D, 1,  1, 2'b10, 2'd3, 12'hABC, 64, 0, 32'h0BADF00D};
        tbl[6] = '{0, 16'hA000, 32'h0,        0,  32'h0,        2,  0, 2'b00, 2'd0, 12'h000, 0,  1, 32'h0};
        tbl[7] = '{1, 16'h3FFF, 32'hA5A5A5A5, 5,  32'h77777777, 0,  1, 2'b01, 2'd3, 12'hFFF, 6,  0, 32'h0};
        tbl[8] = '{0, 16'hFFFF, 32'h0,        0,  32'h0,        0,  0, 2'b00, 2'd1, 12'hFFF, 0,  1, 32'h0};
        tbl[9] = '{0, 16'h6000, 32'h0,        1,  32'h89ABCDEF, 0,  0, 2'b10, 2'd0, 12'h000, 2,  0, 32'h89ABCDEF};
        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // Reset while a unit access is outstanding.
        req_valid = 1; req_write = 0; req_addr = 16'h0008;
        step();
        req_valid = 0;
        step(); step();
        chk("pre_rst_unit_req", unit_req, 2'b01);
        rst = 1;
        step();
        chk("mid_rst_unit_req", unit_req, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        rst = 0;
        #1;
        chk("after_rst_req_ready", req_ready, 1);
        step(); step();
        chk("after_rst_no_rsp", rsp_valid, 0);
        exp_txn = 0; exp_errc = 0;
`ifdef SNN_CSR_ROUTER_STATS_EN
        chk("rst_stat_txn", stat_txn_cnt, 0);
        chk("rst_stat_err", stat_err_cnt, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            dly = r < 7 ? int'($urandom_range(0, 6)) : (r == 7 ? -1 : (r == 8 ? 63 : 64));
            v = model(1'($urandom), 16'($urandom), $urandom, dly, $urandom,
                      int'($urandom_range(0, 3)), 1'($urandom));
            run_txn(v);
        end
`ifdef SNN_CSR_ROUTER_STATS_EN
        chk("stat_txn", stat_txn_cnt, 64'(exp_txn));
        chk("stat_err", stat_err_cnt, 64'(exp_errc));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
